// File: rtl/spi_nav_pkg.sv
// Shared types and constants for the SPI navigation-sensor responder.
package spi_nav_pkg;

   localparam int ADDR_W  = 6;
   localparam int DATA_W  = 8;
   localparam int RNW_BIT = 7;
   localparam logic [ADDR_W-1:0] WHO_AM_I_ADDR = 6'h0F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA
   } state_t;

   // Address after a data byte: wraps 6'h3F -> 6'h00, or stays put when
   // auto-increment is disabled.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input bit inc);
      return inc ? a + ADDR_W'(1) : a;
   endfunction

endpackage

// File: rtl/spi_nav_responder_if.sv
// SPI bus between a master and the navigation-sensor responder.
interface spi_nav_responder_if;
   logic cs_ag;
   logic spc;
   logic sdi;
   logic sdo;
   logic sdo_oe;

   modport master (output cs_ag, spc, sdi, input  sdo, sdo_oe);
   modport slave  (input  cs_ag, spc, sdi, output sdo, sdo_oe);
endinterface

// File: rtl/spi_nav_responder_sync.sv
// Two-flop synchroniser for one asynchronous input, plus edge detection on
// the synchronised level.
module spi_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [1:0] sync_q;
   logic       prev_q;

   // Metastability chain and one-cycle-delayed copy for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      if (rst) begin
         sync_q <= {2{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[0], din};
         prev_q <= sync_q[1];
      end
   end

   assign level = sync_q[1];
   assign rise  =  sync_q[1] & ~prev_q;
   assign fall  = ~sync_q[1] &  prev_q;

endmodule

// File: rtl/spi_nav_responder.sv
// SPI mode-3 register-file responder: 8-bit command (RnW + 6-bit address)
// followed by data bytes, with burst auto-increment and a local preload port.
module spi_nav_responder
   import spi_nav_pkg::*;
#(
   parameter logic [DATA_W-1:0] WHO_AM_I = 8'h68,
   parameter bit                AUTO_INC = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   spi_nav_responder_if.slave spi,
   input  logic               reg_we,
   input  logic [ADDR_W-1:0]  reg_addr,
   input  logic [DATA_W-1:0]  reg_wdata,
   output logic               xfer_done
);

   logic cs_lvl, cs_rise, cs_fall;
   logic spc_level_unused, spc_rise, spc_fall;
   logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

   spi_sync #(.RST_VAL(1'b1)) u_sync_cs  (.clk(clk), .rst(rst), .din(spi.cs_ag),
      .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
   spi_sync #(.RST_VAL(1'b1)) u_sync_spc (.clk(clk), .rst(rst), .din(spi.spc),
      .level(spc_level_unused), .rise(spc_rise), .fall(spc_fall));
   spi_sync #(.RST_VAL(1'b0)) u_sync_sdi (.clk(clk), .rst(rst), .din(spi.sdi),
      .level(sdi_lvl), .rise(sdi_rise_unused), .fall(sdi_fall_unused));

   state_t              state_q, state_d;
   logic [2:0]          bit_cnt_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                rnw_q;
   logic [DATA_W-1:0]   shift_in_q, shift_out_q;
   logic                sdo_q, sdo_oe_q, xfer_done_q;
   logic [1:0]          warm_q;
   logic                armed_q;
   logic [DATA_W-1:0]   regs [2**ADDR_W];

   logic [DATA_W-1:0]   byte_in;
   logic                byte_end;
   logic                spi_commit;
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   rd_data;

   assign byte_in    = {shift_in_q[DATA_W-2:0], sdi_lvl};
   assign byte_end   = spc_rise && (bit_cnt_q == 3'd7) && !cs_rise;
   assign spi_commit = (state_q == ST_DATA) && !rnw_q && byte_end &&
                       (addr_q != WHO_AM_I_ADDR);

   // Read source: the command's start address on the 8th command bit,
   // otherwise the next burst address.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      rd_addr = byte_in[ADDR_W-1:0];
      if (state_q == ST_DATA) rd_addr = next_addr(addr_q, AUTO_INC);
      rd_data = (rd_addr == WHO_AM_I_ADDR) ? WHO_AM_I : regs[rd_addr];
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state; a frame only starts once cs has been seen genuinely
   // high after reset, so a reset in mid-frame never resyncs into it.
   always_comb begin
      state_d = state_q;
      if (cs_rise) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: if (cs_fall && armed_q) state_d = ST_CMD;
            ST_CMD:  if (byte_end)           state_d = ST_DATA;
            ST_DATA: state_d = ST_DATA;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Bit counting, command decode, address advance and read shifting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q   <= '0;
         addr_q      <= '0;
         rnw_q       <= 1'b0;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         sdo_q       <= 1'b0;
         sdo_oe_q    <= 1'b0;
         xfer_done_q <= 1'b0;
         warm_q      <= '0;
         armed_q     <= 1'b0;
      end else begin
         xfer_done_q <= cs_rise && (state_q != ST_IDLE);
         warm_q      <= {warm_q[0], 1'b1};
         if (warm_q[1] && cs_lvl) armed_q <= 1'b1;

         if (cs_rise || state_q == ST_IDLE) begin
            bit_cnt_q <= '0;
            sdo_q     <= 1'b0;
            sdo_oe_q  <= 1'b0;
         end else begin
            if (spc_rise) begin
               shift_in_q <= byte_in;
               bit_cnt_q  <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  if (state_q == ST_CMD) begin
                     rnw_q  <= byte_in[RNW_BIT];
                     addr_q <= byte_in[ADDR_W-1:0];
                     if (byte_in[RNW_BIT]) shift_out_q <= rd_data;
                  end else begin
                     addr_q <= next_addr(addr_q, AUTO_INC);
                     if (rnw_q) shift_out_q <= rd_data;
                  end
               end
            end
            if (spc_fall && state_q == ST_DATA && rnw_q) begin
               sdo_q       <= shift_out_q[DATA_W-1];
               shift_out_q <= {shift_out_q[DATA_W-2:0], 1'b0};
               sdo_oe_q    <= 1'b1;
            end
         end
      end
   end

   // Register file; the SPI commit is written last so it wins a same-cycle,
   // same-address collision with the local port.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: this register file is cleared by reset, so it is built from
      // flops rather than a RAM macro.
      if (rst) begin
         for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      end else begin
         if (reg_we && reg_addr != WHO_AM_I_ADDR) regs[reg_addr] <= reg_wdata;
         if (spi_commit) regs[addr_q] <= byte_in;
      end
   end

   assign spi.sdo    = sdo_q;
   assign spi.sdo_oe = sdo_oe_q;
   assign xfer_done  = xfer_done_q;

endmodule

// File: tb/tb_spi_nav_responder.sv
// Directed bench for spi_nav_responder: a byte-level register model predicts
// every read bit, sdo_oe and xfer_done; literal checks pin the model.
module tb_spi_nav_responder;
   import spi_nav_pkg::*;

   localparam logic [7:0] WHO = 8'h68;

   logic       clk = 1'b0;
   logic       rst;
   logic       reg_we;
   logic [5:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       xfer_done;

   spi_nav_responder_if bus ();

   spi_nav_responder #(.WHO_AM_I(WHO), .AUTO_INC(1'b1)) dut (
      .clk(clk), .rst(rst), .spi(bus), .reg_we(reg_we), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .xfer_done(xfer_done));

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   logic [7:0] mem [64];
   logic chk_en = 1'b0;
   logic exp_sdo, exp_oe, exp_done;
   int   done_pulses = 0;
   int   done_cycles = 0;
   logic done_prev = 1'b0;
   logic [23:0] got;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_rd(input logic [5:0] a);
      return (a == 6'h0F) ? WHO : mem[a];
   endfunction

   // Per-cycle comparison of the DUT outputs against the model expectations.
   always @(negedge clk) begin
      #1;
      if (chk_en) begin
         check("sdo", bus.sdo, exp_sdo);
         check("sdo_oe", bus.sdo_oe, exp_oe);
         check("xfer_done", xfer_done, exp_done);
      end
   end

   // xfer_done pulse counter.
   always @(negedge clk) begin
      if (xfer_done) done_cycles++;
      if (xfer_done && !done_prev) done_pulses++;
      done_prev = xfer_done;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic idle_window(input int n);
      exp_sdo = 1'b0; exp_oe = 1'b0; exp_done = 1'b0;
      chk_en = 1'b1;
      repeat (n) @(negedge clk);
      chk_en = 1'b0;
   endtask

   // Shift n bits of 'bits' (MSB first) with cs already low. When rd_frame is
   // set, bits from index 8 on must be driven from exp_rd.
   task automatic spi_bits(input logic [31:0] bits, input int n, input logic rd_frame,
                           input logic [23:0] exp_rd, output logic [23:0] cap);
      cap = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.spc = 1'b0;
         bus.sdi = bits[31-i];
         repeat (4) @(negedge clk);
         exp_done = 1'b0;
         exp_oe   = rd_frame && (i >= 8);
         exp_sdo  = exp_oe ? exp_rd[31-i] : 1'b0;
         chk_en   = 1'b1;
         repeat (4) @(negedge clk);
         chk_en = 1'b0;
         if (i >= 8) cap[31-i] = bus.sdo;
         bus.spc = 1'b1;
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic spi_xfer(input logic [7:0] cmd, input logic [23:0] data, input int nbits,
                           output logic [23:0] cap);
      logic        is_rd;
      logic [5:0]  a0, ak;
      logic [23:0] exp_rd;
      is_rd = cmd[7];
      a0    = cmd[5:0];
      for (int k = 0; k < 3; k++) begin
         ak = a0 + 6'(k);
         exp_rd[23-8*k -: 8] = model_rd(ak);
      end
      done_pulses = 0;
      done_cycles = 0;
      @(negedge clk);
      bus.cs_ag = 1'b0;
      repeat (4) @(negedge clk);
      spi_bits({cmd, data}, nbits, is_rd, exp_rd, cap);
      bus.cs_ag = 1'b1;
      repeat (8) @(negedge clk);
      check("xfer_done_pulses", done_pulses, 1);
      check("xfer_done_width", done_cycles, 1);
      idle_window(4);
      if (!is_rd && nbits > 8) begin
         for (int k = 0; k < (nbits - 8) / 8; k++) begin
            ak = a0 + 6'(k);
            if (ak != 6'h0F) mem[ak] = data[23-8*k -: 8];
         end
      end
   endtask

   task automatic preload(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_we = 1'b0;
      if (a != 6'h0F) mem[a] = d;
   endtask

   initial begin
      bus.cs_ag = 1'b1; bus.spc = 1'b1; bus.sdi = 1'b0;
      reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      idle_window(2);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // WHO_AM_I read.
      spi_xfer(8'h8F, 24'h0, 16, got);
      check("who_am_i", got[23:16], 8'h68);

      // Write then read back.
      spi_xfer(8'h20, 24'hA50000, 16, got);
      spi_xfer(8'hA0, 24'h0, 16, got);
      check("wr_rd_20", got[23:16], 8'hA5);

      // Burst write across the 3F -> 00 wrap, then burst read it back.
      spi_xfer(8'h3E, 24'h112233, 32, got);
      spi_xfer(8'hBE, 24'h0, 32, got);
      check("burst_wrap", got, 24'h112233);
      spi_xfer(8'h80, 24'h0, 16, got);
      check("wrap_reg00", got[23:16], 8'h33);

      // Local preload, contiguous burst read.
      preload(6'h10, 8'h01);
      preload(6'h11, 8'h02);
      preload(6'h12, 8'h03);
      spi_xfer(8'h90, 24'h0, 32, got);
      check("preload_burst", got, 24'h010203);

      // Partial data byte and partial command byte are discarded.
      spi_xfer(8'h20, 24'h5A0000, 13, got);
      spi_xfer(8'h20, 24'h5A0000, 5, got);
      spi_xfer(8'hA0, 24'h0, 16, got);
      check("partial_discard", got[23:16], 8'hA5);

      // WHO_AM_I is read-only from both write paths.
      spi_xfer(8'h0F, 24'hFF0000, 16, got);
      preload(6'h0F, 8'h55);
      spi_xfer(8'h8F, 24'h0, 16, got);
      check("who_am_i_ro", got[23:16], 8'h68);

      // Reset after 12 spc edges of a write; cs stays low through reset.
      @(negedge clk);
      bus.cs_ag = 1'b0;
      repeat (4) @(negedge clk);
      spi_bits(32'h2077_0000, 6, 1'b0, 24'h0, got);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      idle_window(3);
      rst = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      done_pulses = 0;
      done_cycles = 0;
      repeat (4) @(negedge clk);
      // The rest of that frame must be ignored: no resync, no driving.
      spi_bits(32'h8F00_0000, 16, 1'b0, 24'h0, got);
      bus.cs_ag = 1'b1;
      repeat (8) @(negedge clk);
      check("no_resync_done", done_pulses, 0);
      idle_window(4);

      spi_xfer(8'h8F, 24'h0, 16, got);
      check("post_rst_who", got[23:16], 8'h68);
      spi_xfer(8'hA0, 24'h0, 16, got);
      check("post_rst_reg20", got[23:16], 8'h00);
      spi_xfer(8'h90, 24'h0, 32, got);
      check("post_rst_burst", got, 24'h000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_nav_responder.md
SPI_NAV_RESPONDER -- requirements
Module: spi_nav_responder

Interface
REQ-001 SHALL have parameter WHO_AM_I, default 8'h68, value returned at address 6'h0F (read-only).
REQ-002 SHALL have parameter AUTO_INC, default 1; 1 = address increments per data byte, 0 = address fixed.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cs_ag  input  1  SPI chip select, active low, asynchronous to clk.
REQ-006 SHALL have port spc  input  1  SPI clock, mode 3 (idle high), asynchronous to clk.
REQ-007 SHALL have port sdi  input  1  serial data in (MOSI), MSB first.
REQ-008 SHALL have port sdo  output  1  serial data out (MISO), MSB first.
REQ-009 SHALL have port sdo_oe  output  1  high while a read data phase is driving sdo.
REQ-010 SHALL have ports reg_we input 1, reg_addr input 6, reg_wdata input 8: local preload port for the register file.
REQ-011 SHALL have port xfer_done  output  1  one-cycle pulse on cs_ag rising edge ending a transaction.

Function
REQ-012 SHALL synchronise cs_ag, spc, sdi with 2-FF synchronisers and detect edges on the synchronised signals; clk SHALL be >= 8x spc frequency.
REQ-013 SHALL implement FSM IDLE -> CMD -> DATA; any synchronised cs_ag rise returns to IDLE from any state.
REQ-014 IDLE -> CMD on synchronised cs_ag fall; bit counter cleared.
REQ-015 SHALL sample sdi on spc rising edges and update sdo on spc falling edges.
REQ-016 CMD: after 8 samples, bit7 = RnW (1 = read), bit6 ignored, bits5:0 = start address; then -> DATA.
REQ-017 Read: on 8th command sample, load shift register with reg[addr] (WHO_AM_I at 0x0F); MSB appears on sdo at the next spc falling edge, sdo_oe asserted from that edge until cs_ag rise.
REQ-018 Read: after each 8 data bits, advance address (if AUTO_INC) and reload shift register so the next byte's MSB drives on the following falling edge without a gap.
REQ-019 Write: after each 8th data sample, commit byte to reg[addr] in that cycle, then advance address (if AUTO_INC).
REQ-020 Address increment SHALL wrap 6'h3F -> 6'h00.
REQ-021 Writes to 0x0F SHALL be ignored (SPI and local port).
REQ-022 Partial data bytes (<8 bits) at cs_ag rise SHALL be discarded; partial command byte causes no access.
REQ-023 Local port write when reg_we=1 at rising clk; if same cycle and same address as an SPI commit, SPI data wins.
REQ-024 sdo SHALL be 0 and sdo_oe 0 whenever not in a read data phase.
REQ-025 xfer_done SHALL pulse one cycle after synchronised cs_ag rise, only if the FSM left IDLE.

Reset
REQ-026 On rst: FSM IDLE, counters/address/shift registers 0, sdo 0, sdo_oe 0, xfer_done 0, register file all 8'h00, synchronisers to idle values (cs_ag 1, spc 1, sdi 0).
REQ-027 rst mid-transaction SHALL abort with no commit; module then waits for a fresh cs_ag fall (no resync into an ongoing frame).

Structure
REQ-028 Shared package spi_nav_pkg SHALL hold the FSM state typedef, address width (6), WHO_AM_I address (6'h0F) and RnW bit index.
REQ-029 One sub-module spi_sync (2-FF synchroniser with rise/fall outputs, parameterised reset value) SHALL be instantiated per SPI input.

Verification
REQ-030 Read WHO_AM_I: cmd 8'h8F, 8 clocks -> sdo byte 8'h68, sdo_oe high during data, xfer_done pulses once.
REQ-031 Write then read: write 8'h20 data 8'hA5; read 8'hA0 -> 8'hA5.
REQ-032 Burst write at 0x3E data 11,22,33 (AUTO_INC=1) -> reg[3E]=11, reg[3F]=22, reg[00]=33 (wrap).
REQ-033 Preload reg[10..12]=01,02,03 via local port; burst read 8'h90 24 data bits -> 01,02,03 contiguous.
REQ-034 Write 8'h20 with only 5 data bits then cs_ag rise -> reg[20] unchanged; write 8'h0F data FF -> readback 8'h68.
REQ-035 Assert rst after 12 spc edges of a write -> no commit, all outputs 0, next full read transaction correct.
